operand_row_buffer: RTL

//  Producer side of the systolic controller's a/b operand handshake (x_valid/x_ready).

---
 rtl/operand_row_buffer.sv | 138 +++++++++++++
 1 files changed

// File: rtl/operand_row_buffer.sv
// operand_row_buffer: packs a row-major element stream into a ROWS x COLS tile, then serves it one row per handshake.
// Defining OPERAND_BUF_PAD_EN lets in_last end a tile early; elements past the received count are served as zero.
// state | meaning
// FILL  | accepting host elements into storage
// SERVE | presenting stored rows to the controller
module operand_row_buffer #(
  parameter int DATA_W = 8,
  parameter int COLS   = 8,
  parameter int ROWS   = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [COLS*DATA_W-1:0]  out_data,
  output logic [$clog2(ROWS)-1:0] out_row,
  output logic                    out_last
);
  localparam int ROW_W = $clog2(ROWS);
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;

  typedef enum logic {FILL, SERVE} state_t;
  state_t state, state_nxt;

  logic [DATA_W-1:0] mem [ROWS][COLS];
  logic [COL_W-1:0]  wr_col;
  logic [ROW_W-1:0]  wr_row;
  logic [ROW_W-1:0]  rd_row;
  logic              in_xfer, out_hs, tile_end;
  logic              last_col, last_wr_row, last_rd_row;

  assign last_col    = (wr_col == COL_W'(COLS - 1));
  assign last_wr_row = (wr_row == ROW_W'(ROWS - 1));
  assign last_rd_row = (rd_row == ROW_W'(ROWS - 1));

  // Decoded from state directly so the handshakes do not loop through the FSM outputs.
  assign in_xfer = in_valid && (state == FILL);
  assign out_hs  = out_ready && (state == SERVE);

`ifdef OPERAND_BUF_PAD_EN
  localparam int CNT_W = $clog2(ROWS * COLS + 1);
  logic [CNT_W-1:0] cnt;

  assign tile_end = in_xfer && ((last_col && last_wr_row) || in_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (in_xfer) begin
      cnt <= cnt + CNT_W'(1);
    end else if (out_hs && last_rd_row) begin
      cnt <= '0;
    end
  end
`else
  logic unused_in_last;
  assign unused_in_last = in_last;
  assign tile_end = in_xfer && last_col && last_wr_row;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      FILL: begin
        in_ready = 1'b1;
        if (tile_end) state_nxt = SERVE;
      end
      SERVE: begin
        out_valid = 1'b1;
        if (out_hs && last_rd_row) state_nxt = FILL;
      end
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_col <= '0;
      wr_row <= '0;
      rd_row <= '0;
    end else begin
      if (tile_end) begin
        wr_col <= '0;
        wr_row <= '0;
      end else if (in_xfer) begin
        if (last_col) begin
          wr_col <= '0;
          wr_row <= wr_row + ROW_W'(1);
        end else begin
          wr_col <= wr_col + COL_W'(1);
        end
      end
      if (out_hs) rd_row <= last_rd_row ? '0 : rd_row + ROW_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          mem[r][c] <= '0;
        end
      end
    end else if (in_xfer) begin
      mem[wr_row][wr_col] <= in_data;
    end
  end

  always_comb begin
    out_data = '0;
    if (state == SERVE) begin
      for (int c = 0; c < COLS; c++) begin
`ifdef OPERAND_BUF_PAD_EN
        if (int'(rd_row) * COLS + c < int'(cnt))
`endif
          out_data[c*DATA_W +: DATA_W] = mem[rd_row][c];
      end
    end
  end

  assign out_row  = rd_row;
  assign out_last = out_valid && last_rd_row;

endmodule
